// File: rtl/multicast_fork.sv
// multicast_fork: N-way eager fork with a small input FIFO and per-flit destination mask.
// Optional per-output delivery counters are enabled with `define MULTICAST_FORK_CNT_EN.
module multicast_fork #(
  parameter int WIDTH   = 4,
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l_valid,
  output logic               l_ready,
  input  logic [WIDTH-1:0]   l_data,
  input  logic [NUM_OUT-1:0] l_mask,
  output logic [NUM_OUT-1:0] r_valid,
  input  logic [NUM_OUT-1:0] r_ready,
  output logic [WIDTH-1:0]   r_data
`ifdef MULTICAST_FORK_CNT_EN
  ,
  output logic [16*NUM_OUT-1:0] cnt_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0]   mem_data_q [DEPTH];
  logic [NUM_OUT-1:0] mem_mask_q [DEPTH];

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [NUM_OUT-1:0] pending_q, pending_d;

  logic               push, pop, not_empty;
  logic [NUM_OUT-1:0] hs;
  logic [AW-1:0]      rd_ptr_nxt;

  assign not_empty  = (count_q != '0);
  assign l_ready    = !reset && (count_q < DEPTH_C);
  assign push       = l_valid && l_ready;
  assign r_valid    = {NUM_OUT{not_empty}} & pending_q;
  assign r_data     = mem_data_q[rd_ptr_q];
  assign hs         = r_valid & r_ready;
  // Head retires once no selected output is still outstanding after this edge.
  assign pop        = not_empty && ((pending_q & ~hs) == '0);
  assign rd_ptr_nxt = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pending_d = pending_q & ~hs;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_nxt;

    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // Load pending whenever a new entry becomes head.
    if (push && !not_empty) begin
      pending_d = l_mask;
    end else if (pop) begin
      if (count_q > ONE_C)  pending_d = mem_mask_q[rd_ptr_nxt];
      else if (push)        pending_d = l_mask;
      else                  pending_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= l_data;
      mem_mask_q[wr_ptr_q] <= l_mask;
    end
  end

`ifdef MULTICAST_FORK_CNT_EN
  logic [15:0] cnt_q [NUM_OUT];

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (reset)       cnt_q[gi] <= '0;
      else if (hs[gi]) cnt_q[gi] <= cnt_q[gi] + 16'd1;
    end
    assign cnt_out[16*gi +: 16] = cnt_q[gi];
  end
`endif

endmodule
